// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// Every output is decoded from flops, so the upstream ready path has no combinational loop.
module pipe_stage_skid #(
    parameter int                 DATA_W = 32,
    parameter logic [DATA_W-1:0]  BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic [1:0]        occupancy_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire, out_fire;

    assign in_ready_o  = (state_q != TWO);
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = main_q;
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;

    always_comb begin
        occupancy_o = 2'd0;
        case (state_q)
            ONE:     occupancy_o = 2'd1;
            TWO:     occupancy_o = 2'd2;
            default: occupancy_o = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Flush wins over everything; a coincident accept is dropped, a coincident delivery stands.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data_i;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data_i;
                    end else if (in_fire) begin
                        skid_d  = in_data_i;
                        state_d = TWO;
                    end else if (out_fire) begin
                        main_d  = BUBBLE;
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized checks of pipe_stage_skid at DATA_W=64 with a non-zero bubble.
// Expected values are hand-computed for directed steps and come from a queue model for random steps.
module tb_pipe_stage_skid;

    localparam int          DATA_W = 64;
    localparam logic [63:0] BUB    = 64'hDEAD_BEEF_CAFE_0001;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [1:0]        occupancy;

    int checks;
    int failures;

    pipe_stage_skid #(.DATA_W(DATA_W), .BUBBLE(BUB)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .occupancy_o (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [63:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic v, input logic [63:0] d,
                               input logic rdy, input logic [1:0] occ);
        check_output({tag, "_valid"}, {63'd0, out_valid}, {63'd0, v});
        check_output({tag, "_data"},  out_data, d);
        check_output({tag, "_ready"}, {63'd0, in_ready}, {63'd0, rdy});
        check_output({tag, "_occ"},   {62'd0, occupancy}, {62'd0, occ});
    endtask

    logic [63:0] model_q[$];
    logic [63:0] exp_data;
    logic        r_valid, r_ready, r_flush, m_in_fire, m_out_fire;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        apply_stimulus(1'b1, 64'h55, 1'b1, 1'b0);

        // Reset held with upstream valid asserted
        tick(); tick(); tick();
        check_state("reset", 1'b0, BUB, 1'b1, 2'd0);
        rst = 1'b1;
        tick();
        check_state("first_accept", 1'b1, 64'h55, 1'b1, 2'd1);
        apply_stimulus(1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        check_state("drain_after_reset", 1'b0, BUB, 1'b1, 2'd0);

        // Streaming at full throughput
        apply_stimulus(1'b1, 64'h11, 1'b1, 1'b0);
        tick();
        check_state("stream_11", 1'b1, 64'h11, 1'b1, 2'd1);
        apply_stimulus(1'b1, 64'h22, 1'b1, 1'b0);
        tick();
        check_state("stream_22", 1'b1, 64'h22, 1'b1, 2'd1);
        apply_stimulus(1'b1, 64'h33, 1'b1, 1'b0);
        tick();
        check_state("stream_33", 1'b1, 64'h33, 1'b1, 2'd1);
        apply_stimulus(1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        check_state("stream_end", 1'b0, BUB, 1'b1, 2'd0);

        // Back-pressure fills the skid entry
        apply_stimulus(1'b1, 64'hA1, 1'b0, 1'b0);
        tick();
        check_state("bp_a1", 1'b1, 64'hA1, 1'b1, 2'd1);
        apply_stimulus(1'b1, 64'hA2, 1'b0, 1'b0);
        tick();
        check_state("bp_full", 1'b1, 64'hA1, 1'b0, 2'd2);
        apply_stimulus(1'b1, 64'hA9, 1'b0, 1'b0);
        tick();
        check_state("bp_hold", 1'b1, 64'hA1, 1'b0, 2'd2);
        apply_stimulus(1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        check_state("bp_drain_a2", 1'b1, 64'hA2, 1'b1, 2'd1);
        tick();
        check_state("bp_empty", 1'b0, BUB, 1'b1, 2'd0);

        // Flush while full, with a new payload offered
        apply_stimulus(1'b1, 64'hB1, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, 64'hB2, 1'b0, 1'b0);
        tick();
        check_state("pre_flush_full", 1'b1, 64'hB1, 1'b0, 2'd2);
        apply_stimulus(1'b1, 64'hB3, 1'b0, 1'b1);
        tick();
        check_state("flush_two", 1'b0, BUB, 1'b1, 2'd0);
        apply_stimulus(1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        check_state("after_flush", 1'b0, BUB, 1'b1, 2'd0);

        // Flush coincident with delivery of 0xC1
        apply_stimulus(1'b1, 64'hC1, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 64'h0, 1'b1, 1'b1);
        check_state("c1_delivered", 1'b1, 64'hC1, 1'b1, 2'd1);
        tick();
        check_state("flush_out_fire", 1'b0, BUB, 1'b1, 2'd0);
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);

        // Random traffic against a reference queue
        model_q.delete();
        for (int i = 0; i < 400; i++) begin
            r_valid = ($urandom_range(0, 9) < 7);
            r_ready = ($urandom_range(0, 9) < 6);
            r_flush = ($urandom_range(0, 19) == 0);
            apply_stimulus(r_valid, {$urandom, $urandom}, r_ready, r_flush);
            exp_data = (model_q.size() > 0) ? model_q[0] : BUB;
            check_output("rand_valid", {63'd0, out_valid}, {63'd0, model_q.size() > 0});
            check_output("rand_ready", {63'd0, in_ready},  {63'd0, model_q.size() < 2});
            check_output("rand_occ",   {62'd0, occupancy}, 64'(model_q.size()));
            check_output("rand_data",  out_data, exp_data);
            m_in_fire  = r_valid && (model_q.size() < 2);
            m_out_fire = r_ready && (model_q.size() > 0);
            if (r_flush) begin
                model_q.delete();
            end else begin
                if (m_out_fire) void'(model_q.pop_front());
                if (m_in_fire)  model_q.push_back(in_data);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
